// File: rtl/fp_pkg.sv
// ============================================================================
// Module : fp_pkg
// Brief  : Shared FP32 constants, dot-product FSM state type and the FP32
//          multiply/add arithmetic used by the multiplier and adder units.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fp_pkg;

    localparam logic [31:0] FP_ZERO     = 32'h00000000;
    localparam int          FP_SIGN_BIT = 31;
    localparam logic [31:0] FP_QNAN     = 32'h7FC00000;

    typedef enum logic [2:0] {
        GET      = 3'd0,
        MUL      = 3'd1,
        MUL_WAIT = 3'd2,
        ADD      = 3'd3,
        ADD_WAIT = 3'd4,
        OUT      = 3'd5
    } dot_state_t;

    // Round-to-nearest-even on a 24-bit significand (hidden bit included),
    // then saturate to infinity or flush to signed zero.
    function automatic logic [31:0] fp_pack(input logic s, input int e,
                                            input logic [23:0] m,
                                            input logic g, input logic st);
        logic [24:0] r;
        int          ee;
        r  = {1'b0, m} + 25'(g & (st | m[0]));
        ee = e;
        if (r[24]) begin
            r  = r >> 1;
            ee = ee + 1;
        end
        if (ee >= 255) return {s, 8'hFF, 23'h0};
        if (ee <= 0)   return {s, 31'h0};
        return {s, 8'(ee), r[22:0]};
    endfunction

    // Denormal inputs are treated as zero.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [47:0] p;
        int          e;
        s      = a[FP_SIGN_BIT] ^ b[FP_SIGN_BIT];
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return FP_QNAN;
        if (a_inf || b_inf)   return {s, 8'hFF, 23'h0};
        if (a_zero || b_zero) return {s, 31'h0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) return fp_pack(s, e + 1, p[47:24], p[23], |p[22:0]);
        return fp_pack(s, e, p[46:23], p[22], |p[21:0]);
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [31:0] x, y;
        logic [26:0] mx, my, lost;
        logic [27:0] sm;
        int          d, e;
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        if (a_nan || b_nan || (a_inf && b_inf && (a[FP_SIGN_BIT] != b[FP_SIGN_BIT])))
            return FP_QNAN;
        if (a_inf)  return {a[FP_SIGN_BIT], 8'hFF, 23'h0};
        if (b_inf)  return {b[FP_SIGN_BIT], 8'hFF, 23'h0};
        if (a_zero && b_zero) return {a[FP_SIGN_BIT] & b[FP_SIGN_BIT], 31'h0};
        if (a_zero) return b;
        if (b_zero) return a;
        // x carries the larger magnitude and therefore the result sign
        x = a;
        y = b;
        if (b[30:0] > a[30:0]) begin
            x = b;
            y = a;
        end
        mx = {1'b1, x[22:0], 3'b000};
        my = {1'b1, y[22:0], 3'b000};
        d  = int'(x[30:23]) - int'(y[30:23]);
        if (d > 27) d = 27;
        lost = my & ((27'd1 << d) - 27'd1);
        my   = (my >> d) | {26'h0, |lost};
        if (x[FP_SIGN_BIT] == y[FP_SIGN_BIT]) sm = {1'b0, mx} + {1'b0, my};
        else                                  sm = {1'b0, mx} - {1'b0, my};
        if (sm == '0) return FP_ZERO;
        e = int'(x[30:23]);
        if (sm[27]) begin
            sm = {1'b0, sm[27:2], sm[1] | sm[0]};
            e  = e + 1;
        end else begin
            for (int i = 0; i < 26; i++) begin
                if (!sm[26]) begin
                    sm = sm << 1;
                    e  = e - 1;
                end
            end
        end
        return fp_pack(x[FP_SIGN_BIT], e, sm[26:3], sm[2], |sm[1:0]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/adder.sv
// ============================================================================
// Module : adder
// Brief  : FP32 adder with independent stb/ack operand ports and a stb/ack
//          result port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module adder
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    logic [31:0] r_a, r_b, r_z;
    logic        r_have_a, r_have_b, r_a_ack, r_b_ack, r_z_stb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= FP_ZERO;
            r_b      <= FP_ZERO;
            r_z      <= FP_ZERO;
            r_have_a <= 1'b0;
            r_have_b <= 1'b0;
            r_a_ack  <= 1'b0;
            r_b_ack  <= 1'b0;
            r_z_stb  <= 1'b0;
        end else begin
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
            if (!r_z_stb) begin
                if (input_a_stb && !r_have_a && !r_a_ack) begin
                    r_a      <= input_a;
                    r_have_a <= 1'b1;
                    r_a_ack  <= 1'b1;
                end
                if (input_b_stb && !r_have_b && !r_b_ack) begin
                    r_b      <= input_b;
                    r_have_b <= 1'b1;
                    r_b_ack  <= 1'b1;
                end
                if (r_have_a && r_have_b) begin
                    r_z      <= fp_add(r_a, r_b);
                    r_z_stb  <= 1'b1;
                    r_have_a <= 1'b0;
                    r_have_b <= 1'b0;
                end
            end else if (output_z_ack) begin
                r_z_stb <= 1'b0;
            end
        end
    end

    assign input_a_ack  = r_a_ack;
    assign input_b_ack  = r_b_ack;
    assign output_z     = r_z;
    assign output_z_stb = r_z_stb;

endmodule

`default_nettype wire

// File: rtl/multiplier.sv
// ============================================================================
// Module : multiplier
// Brief  : FP32 multiplier with independent stb/ack operand ports and a
//          stb/ack result port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multiplier
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    logic [31:0] r_a, r_b, r_z;
    logic        r_have_a, r_have_b, r_a_ack, r_b_ack, r_z_stb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= FP_ZERO;
            r_b      <= FP_ZERO;
            r_z      <= FP_ZERO;
            r_have_a <= 1'b0;
            r_have_b <= 1'b0;
            r_a_ack  <= 1'b0;
            r_b_ack  <= 1'b0;
            r_z_stb  <= 1'b0;
        end else begin
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
            if (!r_z_stb) begin
                if (input_a_stb && !r_have_a && !r_a_ack) begin
                    r_a      <= input_a;
                    r_have_a <= 1'b1;
                    r_a_ack  <= 1'b1;
                end
                if (input_b_stb && !r_have_b && !r_b_ack) begin
                    r_b      <= input_b;
                    r_have_b <= 1'b1;
                    r_b_ack  <= 1'b1;
                end
                if (r_have_a && r_have_b) begin
                    r_z      <= fp_mul(r_a, r_b);
                    r_z_stb  <= 1'b1;
                    r_have_a <= 1'b0;
                    r_have_b <= 1'b0;
                end
            end else if (output_z_ack) begin
                r_z_stb <= 1'b0;
            end
        end
    end

    assign input_a_ack  = r_a_ack;
    assign input_b_ack  = r_b_ack;
    assign output_z     = r_z;
    assign output_z_stb = r_z_stb;

endmodule

`default_nettype wire

// File: rtl/fp_dot_product.sv
// ============================================================================
// Module : fp_dot_product
// Brief  : Sequential FP32 dot product over LEN stb/ack element pairs using
//          one multiplier and one adder. Define DOT_RELU_EN to clamp
//          sign-set results to +0.0.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fp_dot_product
    import fp_pkg::*;
#(
    parameter int LEN   = 8,
    parameter int CNT_W = $clog2(LEN + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_stb,
    output logic        in_ack,
    output logic [31:0] out_z,
    output logic        out_stb,
    input  logic        out_ack
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(LEN - 1);

    dot_state_t       r_state;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_op_a, r_op_b, r_prod, r_acc, r_out_z;
    logic             r_in_ack, r_out_stb;
    logic             r_mul_a_stb, r_mul_b_stb, r_mul_z_ack;
    logic             r_add_a_stb, r_add_b_stb, r_add_z_ack;

    logic             w_mul_a_ack, w_mul_b_ack, w_mul_z_stb;
    logic             w_add_a_ack, w_add_b_ack, w_add_z_stb;
    logic [31:0]      w_mul_z, w_add_z, w_result;
    logic             w_mul_a_pend, w_mul_b_pend, w_add_a_pend, w_add_b_pend;

    // An operand strobe stays pending until its own ack arrives
    assign w_mul_a_pend = r_mul_a_stb & ~w_mul_a_ack;
    assign w_mul_b_pend = r_mul_b_stb & ~w_mul_b_ack;
    assign w_add_a_pend = r_add_a_stb & ~w_add_a_ack;
    assign w_add_b_pend = r_add_b_stb & ~w_add_b_ack;

`ifdef DOT_RELU_EN
    assign w_result = w_add_z[FP_SIGN_BIT] ? FP_ZERO : w_add_z;
`else
    assign w_result = w_add_z;
`endif

    multiplier u_multiplier (
        .clk          (clk),
        .rst          (rst),
        .input_a      (r_op_a),
        .input_a_stb  (r_mul_a_stb),
        .input_a_ack  (w_mul_a_ack),
        .input_b      (r_op_b),
        .input_b_stb  (r_mul_b_stb),
        .input_b_ack  (w_mul_b_ack),
        .output_z     (w_mul_z),
        .output_z_stb (w_mul_z_stb),
        .output_z_ack (r_mul_z_ack)
    );

    adder u_adder (
        .clk          (clk),
        .rst          (rst),
        .input_a      (r_acc),
        .input_a_stb  (r_add_a_stb),
        .input_a_ack  (w_add_a_ack),
        .input_b      (r_prod),
        .input_b_stb  (r_add_b_stb),
        .input_b_ack  (w_add_b_ack),
        .output_z     (w_add_z),
        .output_z_stb (w_add_z_stb),
        .output_z_ack (r_add_z_ack)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= GET;
            r_count     <= '0;
            r_op_a      <= FP_ZERO;
            r_op_b      <= FP_ZERO;
            r_prod      <= FP_ZERO;
            r_acc       <= FP_ZERO;
            r_out_z     <= FP_ZERO;
            r_in_ack    <= 1'b0;
            r_out_stb   <= 1'b0;
            r_mul_a_stb <= 1'b0;
            r_mul_b_stb <= 1'b0;
            r_mul_z_ack <= 1'b0;
            r_add_a_stb <= 1'b0;
            r_add_b_stb <= 1'b0;
            r_add_z_ack <= 1'b0;
        end else begin
            r_in_ack    <= 1'b0;
            r_mul_z_ack <= 1'b0;
            r_add_z_ack <= 1'b0;
            case (r_state)
                GET: begin
                    if (in_stb && !r_in_ack) begin
                        r_op_a      <= in_a;
                        r_op_b      <= in_b;
                        r_in_ack    <= 1'b1;
                        r_mul_a_stb <= 1'b1;
                        r_mul_b_stb <= 1'b1;
                        r_state     <= MUL;
                    end
                end
                MUL: begin
                    r_mul_a_stb <= w_mul_a_pend;
                    r_mul_b_stb <= w_mul_b_pend;
                    if (!w_mul_a_pend && !w_mul_b_pend) r_state <= MUL_WAIT;
                end
                MUL_WAIT: begin
                    if (w_mul_z_stb) begin
                        r_prod      <= w_mul_z;
                        r_mul_z_ack <= 1'b1;
                        r_add_a_stb <= 1'b1;
                        r_add_b_stb <= 1'b1;
                        r_state     <= ADD;
                    end
                end
                ADD: begin
                    r_add_a_stb <= w_add_a_pend;
                    r_add_b_stb <= w_add_b_pend;
                    if (!w_add_a_pend && !w_add_b_pend) r_state <= ADD_WAIT;
                end
                ADD_WAIT: begin
                    if (w_add_z_stb) begin
                        r_acc       <= w_add_z;
                        r_add_z_ack <= 1'b1;
                        r_count     <= r_count + 1'b1;
                        if (r_count == c_last) begin
                            r_out_z   <= w_result;
                            r_out_stb <= 1'b1;
                            r_state   <= OUT;
                        end else begin
                            r_state <= GET;
                        end
                    end
                end
                OUT: begin
                    if (out_ack) begin
                        r_out_stb <= 1'b0;
                        r_acc     <= FP_ZERO;
                        r_count   <= '0;
                        r_state   <= GET;
                    end
                end
                default: r_state <= GET;
            endcase
        end
    end

    assign in_ack  = r_in_ack;
    assign out_z   = r_out_z;
    assign out_stb = r_out_stb;

endmodule

`default_nettype wire

// File: tb/tb_fp_dot_product.sv
// ============================================================================
// Module : tb_fp_dot_product
// Brief  : Directed self-checking bench for fp_dot_product (LEN=8 and LEN=1).
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fp_dot_product;

    localparam int LEN = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_a, in_b, out_z;
    logic        in_stb, in_ack, out_stb, out_ack;
    logic [31:0] s_in_a, s_in_b, s_out_z;
    logic        s_in_stb, s_in_ack, s_out_stb, s_out_ack;

    int total    = 0;
    int bad      = 0;
    int ack_cnt  = 0;
    int xfer_cnt = 0;

    logic [31:0] vec_a [LEN];
    logic [31:0] vec_b [LEN];

    always #5 clk = ~clk;

    fp_dot_product #(.LEN(LEN)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .in_a    (in_a),
        .in_b    (in_b),
        .in_stb  (in_stb),
        .in_ack  (in_ack),
        .out_z   (out_z),
        .out_stb (out_stb),
        .out_ack (out_ack)
    );

    fp_dot_product #(.LEN(1)) u_dut_len1 (
        .clk     (clk),
        .rst     (rst),
        .in_a    (s_in_a),
        .in_b    (s_in_b),
        .in_stb  (s_in_stb),
        .in_ack  (s_in_ack),
        .out_z   (s_out_z),
        .out_stb (s_out_stb),
        .out_ack (s_out_ack)
    );

    always @(posedge clk) begin
        if (in_ack) ack_cnt++;
        if (out_stb && out_ack) xfer_cnt++;
    end

    task automatic load_case1();
        vec_a = '{32'h3F800000, 32'h40000000, 32'hC0400000, 32'hC0800000,
                  32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
        vec_b = '{32'hC0800000, 32'h40400000, 32'h40000000, 32'hBF800000,
                  32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    endtask

    task automatic send_vec(input int n, input int gap);
        bit got;
        for (int k = 0; k < n; k++) begin
            in_a   = vec_a[k];
            in_b   = vec_b[k];
            in_stb = 1'b1;
            got    = 1'b0;
            for (int c = 0; c < 500; c++) begin
                @(negedge clk);
                if (in_ack) begin
                    got = 1'b1;
                    break;
                end
            end
            in_stb = 1'b0;
            if (!got) begin
                total++;
                bad++;
                $display("FAIL in_ack_timeout element=%0d got=none want=pulse", k);
            end
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic get_result(output logic [31:0] z);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (out_stb) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        z = out_z;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL out_stb_timeout got=none want=out_stb");
        end
    endtask

    task automatic ack_result(input string name);
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        total++;
        if (out_stb !== 1'b0) begin
            bad++;
            $display("FAIL %s_stb_drop got=%b want=0", name, out_stb);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_a = '0; in_b = '0; in_stb = 1'b0; out_ack = 1'b0;
        s_in_a = '0; s_in_b = '0; s_in_stb = 1'b0; s_out_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total += 4;
        if (out_stb !== 1'b0)      begin bad++; $display("FAIL reset_out_stb got=%b want=0", out_stb); end
        if (out_z !== 32'h0)       begin bad++; $display("FAIL reset_out_z got=%h want=00000000", out_z); end
        if (in_ack !== 1'b0)       begin bad++; $display("FAIL reset_in_ack got=%b want=0", in_ack); end
        if (s_out_stb !== 1'b0)    begin bad++; $display("FAIL reset_len1_out_stb got=%b want=0", s_out_stb); end
    endtask

    task automatic test_dot_basic();
        logic [31:0] z;
        load_case1();
        xfer_cnt = 0;
        send_vec(LEN, 0);
        get_result(z);
        total++;
        if (z !== 32'h432E0000) begin bad++; $display("FAIL basic_z got=%h want=432e0000", z); end
        ack_result("basic");
        repeat (5) @(negedge clk);
        total++;
        if (xfer_cnt !== 1) begin bad++; $display("FAIL basic_xfers got=%0d want=1", xfer_cnt); end
    endtask

    task automatic test_negative_sum();
        logic [31:0] z;
        logic [31:0] want;
`ifdef DOT_RELU_EN
        want = 32'h00000000;
`else
        want = 32'hC1000000;
`endif
        for (int k = 0; k < LEN; k++) begin
            vec_a[k] = 32'h3F800000;
            vec_b[k] = 32'hBF800000;
        end
        send_vec(LEN, 0);
        get_result(z);
        total++;
        if (z !== want) begin bad++; $display("FAIL negsum_z got=%h want=%h", z, want); end
        ack_result("negsum");
    endtask

    task automatic test_backpressure();
        logic [31:0] z, z2, z3;
        int stb_bad, z_bad, ack_bad;
        stb_bad = 0; z_bad = 0; ack_bad = 0;
        load_case1();
        send_vec(LEN, 0);
        get_result(z);
        total++;
        if (z !== 32'h432E0000) begin bad++; $display("FAIL hold_z got=%h want=432e0000", z); end
        // Next vector's first pair is offered while the result is held
        in_a = vec_a[0]; in_b = vec_b[0]; in_stb = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_stb !== 1'b1)       stb_bad++;
            if (out_z !== 32'h432E0000) z_bad++;
            if (in_ack !== 1'b0)        ack_bad++;
        end
        total += 3;
        if (stb_bad != 0) begin bad++; $display("FAIL hold_stb_stable got=%0d_drops want=0", stb_bad); end
        if (z_bad != 0)   begin bad++; $display("FAIL hold_z_stable got=%0d_changes want=0", z_bad); end
        if (ack_bad != 0) begin bad++; $display("FAIL hold_in_ack got=%0d_pulses want=0", ack_bad); end
        ack_result("hold");
        send_vec(LEN, 0);
        get_result(z2);
        total++;
        if (z2 !== 32'h432E0000) begin bad++; $display("FAIL b2b_first got=%h want=432e0000", z2); end
        ack_result("b2b_first");
        send_vec(LEN, 0);
        get_result(z3);
        total++;
        if (z3 !== 32'h432E0000) begin bad++; $display("FAIL b2b_second got=%h want=432e0000", z3); end
        ack_result("b2b_second");
    endtask

    task automatic test_gapped_input();
        logic [31:0] z;
        load_case1();
        ack_cnt = 0;
        send_vec(LEN, 5);
        get_result(z);
        total++;
        if (z !== 32'h432E0000) begin bad++; $display("FAIL gapped_z got=%h want=432e0000", z); end
        ack_result("gapped");
        total++;
        if (ack_cnt !== LEN) begin bad++; $display("FAIL gapped_acks got=%0d want=%0d", ack_cnt, LEN); end
    endtask

    task automatic test_abort();
        logic [31:0] z;
        load_case1();
        send_vec(3, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (out_stb !== 1'b0) begin bad++; $display("FAIL abort_out_stb got=%b want=0", out_stb); end
        send_vec(LEN, 0);
        get_result(z);
        total++;
        if (z !== 32'h432E0000) begin bad++; $display("FAIL abort_z got=%h want=432e0000", z); end
        ack_result("abort");
    endtask

    task automatic test_single_len();
        bit got;
        s_in_a = 32'h40000000;
        s_in_b = 32'h40400000;
        s_in_stb = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (s_in_ack) begin got = 1'b1; break; end
        end
        s_in_stb = 1'b0;
        if (!got) begin total++; bad++; $display("FAIL len1_in_ack_timeout got=none want=pulse"); end
        got = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (s_out_stb) begin got = 1'b1; break; end
            @(negedge clk);
        end
        total++;
        if (!got || s_out_z !== 32'h40C00000) begin
            bad++;
            $display("FAIL len1_z got=%h want=40c00000", s_out_z);
        end
        s_out_ack = 1'b1;
        @(negedge clk);
        s_out_ack = 1'b0;
        total++;
        if (s_out_stb !== 1'b0) begin bad++; $display("FAIL len1_stb_drop got=%b want=0", s_out_stb); end
    endtask

    initial begin
        test_reset();
        test_dot_basic();
        test_negative_sum();
        test_backpressure();
        test_gapped_input();
        test_abort();
        test_single_len();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
